// File: rtl/decode_stage_if.sv
// Bus bundle for the decode stage: fetch handshake, register file read port
// and the ID/EX register outputs.
//   slave  : decode stage view (consumes fetch/regfile/control, drives ID/EX)
//   master : environment view (fetch unit, register file, execute stage)
interface decode_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    // fetch side
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc;
    logic          if_ready;
    // pipeline control
    logic          flush;
    logic          ex_stall;
    // register file read port
    logic [AW-1:0] r_reg1;
    logic [AW-1:0] r_reg2;
    logic [DW-1:0] r_data1;
    logic [DW-1:0] r_data2;
    // ID/EX register
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_imm;
    logic [AW-1:0] ex_wreg;
    logic [5:0]    ex_funct;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_alu_src;
    logic          ex_branch;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_stall, r_data1, r_data2,
        output if_ready, r_reg1, r_reg2,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_wreg, ex_funct,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_stall, r_data1, r_data2,
        input  if_ready, r_reg1, r_reg2,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_wreg, ex_funct,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: IF/ID register, field decode, register
// file addressing, load-use hazard bubble insertion and the ID/EX register.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - decode_stage_if.slave (fetch handshake, regfile read, ID/EX outputs)
module decode_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam int unsigned OPW = 6;
    localparam int unsigned IMW = 16;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;

    // IF/ID register
    logic          ifid_valid;
    logic [DW-1:0] ifid_instr;
    logic [DW-1:0] ifid_pc;

    // instruction fields
    logic [OPW-1:0] op;
    logic [AW-1:0]  rs;
    logic [AW-1:0]  rt;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  imm;

    // decoded controls
    logic          dec_reg_write;
    logic          dec_mem_read;
    logic          dec_mem_write;
    logic          dec_alu_src;
    logic          dec_branch;
    logic          dec_uses_rt;
    logic [AW-1:0] dec_wreg;
    logic          dec_wr_eff;

    logic hz;
    logic advance;

    assign op  = ifid_instr[31:26];
    assign rs  = AW'(ifid_instr[25:21]);
    assign rt  = AW'(ifid_instr[20:16]);
    assign rd  = AW'(ifid_instr[15:11]);
    assign imm = {{(DW-IMW){ifid_instr[IMW-1]}}, ifid_instr[IMW-1:0]};

    // Opcode decode; unknown opcodes fall through as NOPs.
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        dec_uses_rt   = 1'b0;
        dec_wreg      = '0;
        case (op)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_uses_rt   = 1'b1;
                dec_wreg      = rd;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_wreg      = rt;
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_wreg      = rt;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_branch    = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            default: ;
        endcase
    end

    // r0 is hardwired zero, so a write to it is dropped here.
    assign dec_wr_eff = dec_reg_write & (dec_wreg != '0);

    // Register file addresses come straight from IF/ID; idle reads use r0.
    assign bus.r_reg1 = ifid_valid ? rs : '0;
    assign bus.r_reg2 = ifid_valid ? rt : '0;

    // Load in ID/EX whose result the IF/ID instruction needs: one bubble.
    assign hz = bus.ex_valid & bus.ex_mem_read & (bus.ex_wreg != '0) & ifid_valid &
                ((bus.ex_wreg == rs) | ((bus.ex_wreg == rt) & dec_uses_rt));

    assign advance     = ~bus.ex_stall & ~hz;
    assign bus.if_ready = advance;

    // IF/ID and ID/EX registers: reset > flush > stall > hazard > advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid       <= 1'b0;
            ifid_instr       <= '0;
            ifid_pc          <= '0;
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rd1       <= '0;
            bus.ex_rd2       <= '0;
            bus.ex_imm       <= '0;
            bus.ex_wreg      <= '0;
            bus.ex_funct     <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_src   <= 1'b0;
            bus.ex_branch    <= 1'b0;
        end else if (bus.flush) begin
            ifid_valid   <= 1'b0;
            bus.ex_valid <= 1'b0;
        end else if (bus.ex_stall) begin
            // hold everything
        end else if (hz) begin
            // bubble into ID/EX; IF/ID keeps the dependent instruction
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_src   <= 1'b0;
            bus.ex_branch    <= 1'b0;
        end else begin
            bus.ex_valid     <= ifid_valid;
            bus.ex_pc        <= ifid_pc;
            bus.ex_rd1       <= bus.r_data1;
            bus.ex_rd2       <= bus.r_data2;
            bus.ex_imm       <= imm;
            bus.ex_wreg      <= dec_wreg;
            bus.ex_funct     <= ifid_instr[5:0];
            bus.ex_reg_write <= ifid_valid & dec_wr_eff;
            bus.ex_mem_read  <= ifid_valid & dec_mem_read;
            bus.ex_mem_write <= ifid_valid & dec_mem_write;
            bus.ex_alu_src   <= ifid_valid & dec_alu_src;
            bus.ex_branch    <= ifid_valid & dec_branch;
            ifid_valid       <= bus.if_valid;
            if (bus.if_valid) begin
                ifid_instr <= bus.if_instr;
                ifid_pc    <= bus.if_pc;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model built
// from the stage's pipeline rules.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if #(.DW(32), .AW(5)) bus ();

    decode_stage #(.DW(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // register file model: combinational read
    logic [31:0] mem [32];
    assign bus.r_data1 = mem[bus.r_reg1];
    assign bus.r_data2 = mem[bus.r_reg2];

    // driven inputs
    logic        in_valid, in_flush, in_stall;
    logic [31:0] in_instr, in_pc;
    assign bus.if_valid = in_valid;
    assign bus.if_instr = in_instr;
    assign bus.if_pc    = in_pc;
    assign bus.flush    = in_flush;
    assign bus.ex_stall = in_stall;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  wreg;
        logic        has_wreg;
        logic [5:0]  funct;
        logic        rw, mr, mw, as, br;
    } ex_t;

    logic        m_if_valid;
    logic [31:0] m_if_instr, m_if_pc;
    ex_t         m_ex;
    logic        m_ctrl_known;

    function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        ex_t e;
        logic [5:0] op;
        logic [4:0] f_rs, f_rt, f_rd;
        op   = ins[31:26];
        f_rs = ins[25:21];
        f_rt = ins[20:16];
        f_rd = ins[15:11];
        e.valid = 1'b1;
        e.pc    = pc;
        e.rd1   = mem[f_rs];
        e.rd2   = mem[f_rt];
        e.imm   = {{16{ins[15]}}, ins[15:0]};
        e.funct = ins[5:0];
        e.wreg = 5'd0; e.has_wreg = 1'b0;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.as = 1'b0; e.br = 1'b0;
        if (op == 6'd0)        begin e.wreg = f_rd; e.has_wreg = 1'b1; end
        else if (op == 6'd8)   begin e.wreg = f_rt; e.has_wreg = 1'b1; e.as = 1'b1; end
        else if (op == 6'd35)  begin e.wreg = f_rt; e.has_wreg = 1'b1; e.as = 1'b1; e.mr = 1'b1; end
        else if (op == 6'd43)  begin e.as = 1'b1; e.mw = 1'b1; end
        else if (op == 6'd4)   e.br = 1'b1;
        e.rw = e.has_wreg && (e.wreg != 5'd0);
        return e;
    endfunction

    function automatic logic model_hz();
        logic [5:0] op;
        logic [4:0] f_rs, f_rt;
        logic       uses_rt;
        op      = m_if_instr[31:26];
        f_rs    = m_if_instr[25:21];
        f_rt    = m_if_instr[20:16];
        uses_rt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
        return m_ex.valid && m_ex.mr && (m_ex.wreg != 5'd0) && m_if_valid &&
               ((m_ex.wreg == f_rs) || ((m_ex.wreg == f_rt) && uses_rt));
    endfunction

    task automatic model_reset();
        m_if_valid = 1'b0;
        m_if_instr = '0;
        m_if_pc    = '0;
        m_ex       = model_decode(32'hFC00_0000, 32'd0);
        m_ex.valid = 1'b0; m_ex.pc = '0; m_ex.rd1 = '0; m_ex.rd2 = '0;
        m_ex.imm = '0; m_ex.funct = '0; m_ex.wreg = '0; m_ex.has_wreg = 1'b1;
        m_ctrl_known = 1'b1;
    endtask

    task automatic check_ex();
        check("ex_valid", 32'(bus.ex_valid), 32'(m_ex.valid));
        if (m_ex.valid || m_ctrl_known) begin
            check("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_ex.rw));
            check("ex_mem_read",  32'(bus.ex_mem_read),  32'(m_ex.mr));
            check("ex_mem_write", 32'(bus.ex_mem_write), 32'(m_ex.mw));
            check("ex_alu_src",   32'(bus.ex_alu_src),   32'(m_ex.as));
            check("ex_branch",    32'(bus.ex_branch),    32'(m_ex.br));
        end
        if (m_ex.valid) begin
            check("ex_pc",    bus.ex_pc,  m_ex.pc);
            check("ex_rd1",   bus.ex_rd1, m_ex.rd1);
            check("ex_rd2",   bus.ex_rd2, m_ex.rd2);
            check("ex_imm",   bus.ex_imm, m_ex.imm);
            check("ex_funct", 32'(bus.ex_funct), 32'(m_ex.funct));
            if (m_ex.has_wreg) check("ex_wreg", 32'(bus.ex_wreg), 32'(m_ex.wreg));
        end
    endtask

    // One clock: check combinational outputs, advance model, check ID/EX.
    task automatic step();
        logic hz;
        ex_t  nxt;
        #1;
        hz = model_hz();
        check("if_ready", 32'(bus.if_ready), 32'(!in_stall && !hz));
        check("r_reg1", 32'(bus.r_reg1), m_if_valid ? 32'(m_if_instr[25:21]) : 32'd0);
        check("r_reg2", 32'(bus.r_reg2), m_if_valid ? 32'(m_if_instr[20:16]) : 32'd0);
        nxt = m_ex;
        if (in_flush) begin
            nxt.valid = 1'b0;
            m_ctrl_known = 1'b0;
        end else if (in_stall) begin
            // hold
        end else if (hz) begin
            nxt.valid = 1'b0;
            nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0; nxt.as = 1'b0; nxt.br = 1'b0;
            m_ctrl_known = 1'b1;
        end else begin
            nxt = model_decode(m_if_instr, m_if_pc);
            nxt.valid = m_if_valid;
            m_ctrl_known = m_if_valid;
        end
        @(posedge clk);
        #1;
        m_ex = nxt;
        if (in_flush) begin
            m_if_valid = 1'b0;
        end else if (!in_stall && !hz) begin
            m_if_valid = in_valid;
            if (in_valid) begin
                m_if_instr = in_instr;
                m_if_pc    = in_pc;
            end
        end
        check_ex();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic st);
        in_valid = v; in_instr = ins; in_pc = pc; in_flush = fl; in_stall = st;
    endtask

    localparam logic [31:0] I_ADDI_T1 = 32'h2025FFFC; // addi r5,r1,-4
    localparam logic [31:0] I_LW8     = 32'h8C280000; // lw   r8,0(r1)
    localparam logic [31:0] I_ADD9    = 32'h01024820; // add  r9,r8,r2
    localparam logic [31:0] I_ADDI3   = 32'h20830001; // addi r3,r4,1
    localparam logic [31:0] I_ADD0    = 32'h00220020; // add  r0,r1,r2

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [31:0] ins;
        case ($urandom_range(0, 5))
            0: op = 6'd0;
            1: op = 6'd8;
            2: op = 6'd35;
            3: op = 6'd43;
            4: op = 6'd4;
            default: op = 6'($urandom);
        endcase
        ins = $urandom;
        ins[31:26] = op;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'd0 : $urandom;
        mem[1] = 32'h00111334;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst ex_pc", bus.ex_pc, 32'd0);
        check("rst r_reg1", 32'(bus.r_reg1), 32'd0);
        check("rst ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
        reset = 1'b0;

        // 1: ADDI r5,r1,-4 reaches ID/EX one edge after acceptance
        drive(1'b1, I_ADDI_T1, 32'h100, 1'b0, 1'b0); step();
        drive(1'b0, 32'd0, 32'h104, 1'b0, 1'b0);     step();
        check("t1 ex_valid", 32'(bus.ex_valid), 32'd1);
        check("t1 ex_rd1", bus.ex_rd1, 32'h00111334);
        check("t1 ex_imm", bus.ex_imm, 32'hFFFFFFFC);
        check("t1 ex_wreg", 32'(bus.ex_wreg), 32'd5);
        check("t1 ex_reg_write", 32'(bus.ex_reg_write), 32'd1);
        check("t1 ex_alu_src", 32'(bus.ex_alu_src), 32'd1);

        // 2: load-use costs one bubble and holds the next fetch
        drive(1'b1, I_LW8,   32'h200, 1'b0, 1'b0); step();
        drive(1'b1, I_ADD9,  32'h204, 1'b0, 1'b0); step();
        drive(1'b1, I_ADDI3, 32'h208, 1'b0, 1'b0);
        #1 check("t2 if_ready bubble", 32'(bus.if_ready), 32'd0);
        step();
        check("t2 bubble ex_valid", 32'(bus.ex_valid), 32'd0);
        step();
        check("t2 add ex_valid", 32'(bus.ex_valid), 32'd1);
        check("t2 add ex_wreg", 32'(bus.ex_wreg), 32'd9);
        drive(1'b0, 32'd0, 32'h20C, 1'b0, 1'b0); step();
        check("t2 held fetch pc", bus.ex_pc, 32'h208);

        // 3: independent instruction after a load: no bubble
        drive(1'b1, I_LW8,   32'h300, 1'b0, 1'b0); step();
        drive(1'b1, I_ADDI3, 32'h304, 1'b0, 1'b0); step();
        check("t3 lw ex_valid", 32'(bus.ex_valid), 32'd1);
        drive(1'b0, 32'd0, 32'h308, 1'b0, 1'b0);
        #1 check("t3 if_ready", 32'(bus.if_ready), 32'd1);
        step();
        check("t3 addi ex_valid", 32'(bus.ex_valid), 32'd1);
        check("t3 addi ex_pc", bus.ex_pc, 32'h304);

        // 4: three-cycle stall with both stages occupied
        drive(1'b1, I_ADDI3, 32'h400, 1'b0, 1'b0); step();
        drive(1'b1, I_ADD0,  32'h404, 1'b0, 1'b0); step();
        drive(1'b1, I_LW8,   32'h408, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4 stall ex_pc", bus.ex_pc, 32'h400);
        end
        drive(1'b1, I_LW8, 32'h408, 1'b0, 1'b0); step();
        check("t4 resume ex_pc", bus.ex_pc, 32'h404);

        // 5: flush with a concurrent fetch
        drive(1'b1, I_ADDI3, 32'h500, 1'b1, 1'b0); step();
        check("t5 flush ex_valid", 32'(bus.ex_valid), 32'd0);
        check("t5 flush r_reg1", 32'(bus.r_reg1), 32'd0);
        check("t5 flush r_reg2", 32'(bus.r_reg2), 32'd0);
        drive(1'b1, I_ADDI_T1, 32'h504, 1'b0, 1'b0); step();
        drive(1'b0, 32'd0, 32'h508, 1'b0, 1'b0);     step();
        check("t5 after ex_pc", bus.ex_pc, 32'h504);
        check("t5 after ex_wreg", 32'(bus.ex_wreg), 32'd5);

        // 6: write to r0 suppressed; async reset in the middle of a hazard
        drive(1'b1, I_ADD0, 32'h600, 1'b0, 1'b0); step();
        drive(1'b1, I_LW8,  32'h604, 1'b0, 1'b0); step();
        check("t6 r0 ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
        drive(1'b1, I_ADD9, 32'h608, 1'b0, 1'b0); step();
        drive(1'b1, I_ADDI3, 32'h60C, 1'b0, 1'b0);
        #2 check("t6 hazard if_ready", 32'(bus.if_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("t6 rst ex_valid", 32'(bus.ex_valid), 32'd0);
        check("t6 rst ex_pc", bus.ex_pc, 32'd0);
        check("t6 rst ex_rd1", bus.ex_rd1, 32'd0);
        check("t6 rst ex_imm", bus.ex_imm, 32'd0);
        check("t6 rst ex_wreg", 32'(bus.ex_wreg), 32'd0);
        check("t6 rst ex_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check("t6 rst r_reg1", 32'(bus.r_reg1), 32'd0);
        check("t6 rst if_ready", 32'(bus.if_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic
        pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(1, 31)] = $urandom;
            drive(($urandom_range(0, 9) < 8), rand_instr(), pc,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 6) == 0));
            pc = pc + 32'd4;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
